axi_arbiter_w_rr: RTL and testbench

Parametrised round-robin arbiter for the AXI write path of the interconnect; selects one of `NUM_MASTERS` masters and holds that grant for one complete write transaction. A transaction is the AW handshake, the W burst through WLAST, and the B handshake. Sits between the master-side AW/W/B request signals and the shared write-channel mux. The one-hot grant drives the mux selects.

---
 rtl/axi_ic_pkg.sv | 25 ++
 rtl/axi_arbiter_w_rr_if.sv | 30 +++
 rtl/rr_pick.sv | 32 +++
 rtl/axi_arbiter_w_rr.sv | 115 +++++++++++
 tb/tb_axi_arbiter_w_rr.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: arbiter state encoding and round-robin index helper.
package axi_ic_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_XFER = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_IDLE,
    S_XFER = ST_XFER,
    S_RESP = ST_RESP
  } arb_state_e;

  // (base + off) mod n for base, off < n; subtract instead of divide
  function automatic int unsigned rr_rotate(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/axi_arbiter_w_rr_if.sv
// Write-path arbitration bundle: per-master AW/W/B requests, shared slave handshakes, grant outputs.
interface axi_arbiter_w_rr_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = $clog2(NUM_MASTERS)
) ();

  logic [NUM_MASTERS-1:0] mst_AWVALID;
  logic [NUM_MASTERS-1:0] mst_WVALID;
  logic [NUM_MASTERS-1:0] mst_WLAST;
  logic [NUM_MASTERS-1:0] mst_BREADY;
  logic                   m_AWREADY;
  logic                   m_WREADY;
  logic                   m_BVALID;
  logic [NUM_MASTERS-1:0] wgrnt;
  logic [ID_W-1:0]        wgrnt_id;
  logic                   wbusy;

  modport master (
    output mst_AWVALID, mst_WVALID, mst_WLAST, mst_BREADY,
    output m_AWREADY, m_WREADY, m_BVALID,
    input  wgrnt, wgrnt_id, wbusy
  );

  modport slave (
    input  mst_AWVALID, mst_WVALID, mst_WLAST, mst_BREADY,
    input  m_AWREADY, m_WREADY, m_BVALID,
    output wgrnt, wgrnt_id, wbusy
  );

endinterface

// File: rtl/rr_pick.sv
// Rotated priority encoder: first set request at or after ptr (wrapping) wins.
module rr_pick
  import axi_ic_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic                   valid_c,
  output logic [NUM_MASTERS-1:0] onehot_c,
  output logic [ID_W-1:0]        idx_c
);

  logic [ID_W-1:0] cand;

  always_comb begin
    valid_c  = 1'b0;
    onehot_c = '0;
    idx_c    = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = ID_W'(rr_rotate(32'(ptr), k, NUM_MASTERS));
      if (!valid_c && req[cand]) begin
        valid_c  = 1'b1;
        idx_c    = cand;
        onehot_c = NUM_MASTERS'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/axi_arbiter_w_rr.sv
// Round-robin AXI write-path arbiter; holds one grant for AW, the full W burst and the B response.
module axi_arbiter_w_rr
  import axi_ic_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned PARK        = 1,
  parameter int unsigned ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  axi_arbiter_w_rr_if.slave bus
);

  localparam logic [NUM_MASTERS-1:0] GRNT_RST = (PARK != 0) ? NUM_MASTERS'(1) : '0;

  arb_state_e             state, state_nxt;
  logic [ID_W-1:0]        ptr, ptr_nxt;
  logic [ID_W-1:0]        gid, gid_nxt;
  logic [NUM_MASTERS-1:0] grnt, grnt_nxt;
  logic                   busy, busy_nxt;
  logic                   aw_done, aw_nxt;
  logic                   w_done, w_nxt;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [ID_W-1:0]        pick_idx;
  logic                   aw_hs, w_hs, b_hs;

  // W may lead AW, so either channel counts as a request
  assign req = bus.mst_AWVALID | bus.mst_WVALID;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_W        (ID_W)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .valid_c  (pick_valid),
    .onehot_c (pick_onehot),
    .idx_c    (pick_idx)
  );

  assign aw_hs = bus.mst_AWVALID[gid] & bus.m_AWREADY;
  assign w_hs  = bus.mst_WVALID[gid] & bus.m_WREADY & bus.mst_WLAST[gid];
  assign b_hs  = bus.m_BVALID & bus.mst_BREADY[gid];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gid     <= '0;
      grnt    <= GRNT_RST;
      busy    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gid     <= gid_nxt;
      grnt    <= grnt_nxt;
      busy    <= busy_nxt;
      aw_done <= aw_nxt;
      w_done  <= w_nxt;
    end
  end

  // Next-state, flag, pointer and grant logic; stray BVALID outside RESP is ignored
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gid_nxt   = gid;
    grnt_nxt  = grnt;
    busy_nxt  = busy;
    aw_nxt    = aw_done;
    w_nxt     = w_done;
    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grnt_nxt  = pick_onehot;
          gid_nxt   = pick_idx;
          busy_nxt  = 1'b1;
          aw_nxt    = 1'b0;
          w_nxt     = 1'b0;
          state_nxt = S_XFER;
        end else if (PARK == 0) begin
          grnt_nxt = '0;
        end
      end
      S_XFER: begin
        aw_nxt = aw_done | aw_hs;
        w_nxt  = w_done | w_hs;
        if (aw_nxt && w_nxt) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (b_hs) begin
          ptr_nxt   = ID_W'(rr_rotate(32'(gid), 1, NUM_MASTERS));
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.wgrnt    = grnt;
  assign bus.wgrnt_id = gid;
  assign bus.wbusy    = busy;

endmodule

// File: tb/tb_axi_arbiter_w_rr.sv
// Bench for axi_arbiter_w_rr: a 4-master parked instance and a 3-master unparked instance share stimulus.
module tb_axi_arbiter_w_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_arbiter_w_rr_if #(.NUM_MASTERS(4)) ifc4 ();
  axi_arbiter_w_rr_if #(.NUM_MASTERS(3)) ifc3 ();

  axi_arbiter_w_rr #(.NUM_MASTERS(4), .PARK(1)) dut4 (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (ifc4.slave)
  );

  axi_arbiter_w_rr #(.NUM_MASTERS(3), .PARK(0)) dut3 (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (ifc3.slave)
  );

  logic [15:0] aw_v, w_v, wl, br;
  logic        awr, wr, bv;

  assign ifc4.mst_AWVALID = aw_v[3:0];
  assign ifc4.mst_WVALID  = w_v[3:0];
  assign ifc4.mst_WLAST   = wl[3:0];
  assign ifc4.mst_BREADY  = br[3:0];
  assign ifc4.m_AWREADY   = awr;
  assign ifc4.m_WREADY    = wr;
  assign ifc4.m_BVALID    = bv;
  assign ifc3.mst_AWVALID = aw_v[2:0];
  assign ifc3.mst_WVALID  = w_v[2:0];
  assign ifc3.mst_WLAST   = wl[2:0];
  assign ifc3.mst_BREADY  = br[2:0];
  assign ifc3.m_AWREADY   = awr;
  assign ifc3.m_WREADY    = wr;
  assign ifc3.m_BVALID    = bv;

  int nm;      // which instance is under test (4 or 3)
  bit park;
  int mptr;    // reference round-robin pointer
  int errors = 0;
  int checks = 0;

  logic [15:0] g_grnt;
  logic [1:0]  g_id;
  logic        g_busy;
  assign g_grnt = (nm == 4) ? 16'(ifc4.wgrnt)  : 16'(ifc3.wgrnt);
  assign g_id   = (nm == 4) ? ifc4.wgrnt_id    : ifc3.wgrnt_id;
  assign g_busy = (nm == 4) ? ifc4.wbusy       : ifc3.wbusy;

  // Reference: scan ptr, ptr+1, ... modulo n for the first requester
  function automatic int rr_winner(input logic [15:0] req, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (req[(p + k) % n]) return (p + k) % n;
    end
    return 0;
  endfunction

  task automatic zero_inputs();
    aw_v = '0; w_v = '0; wl = '0; br = '0;
    awr = 1'b0; wr = 1'b0; bv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
  endtask

  // One full transaction; called at a negedge while the DUT is idle
  task automatic run_txn(input logic [15:0] req, input bit wfirst, input int aw_start,
                         input int len, input bit rnd, input bit stop_in_resp,
                         output int w);
    logic [15:0] exp_g;
    bit aw_ok, w_ok, resp, done;
    int beats, cyc;
    w = rr_winner(req, mptr, nm);
    exp_g = 16'(1) << w;
    zero_inputs();
    aw_v = req;
    if (wfirst) begin
      aw_v[w] = 1'b0;
      w_v[w]  = 1'b1;
      wl[w]   = (len == 1);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (g_grnt !== exp_g || g_id !== 2'(w) || g_busy !== 1'b1) begin
      errors++;
      $display("FAIL grant: got wgrnt=%h id=%0d busy=%b, want wgrnt=%h id=%0d busy=1",
               g_grnt, g_id, g_busy, exp_g, w);
    end
    aw_ok = 0; w_ok = 0; resp = 0; done = 0; beats = 0; cyc = 0;
    while (!done) begin
      if (cyc > 400) begin
        checks++; errors++;
        $display("FAIL txn_timeout: master %0d got no B within 400 cycles, want completion", w);
        break;
      end
      w_v = rnd ? (16'($urandom()) & ~exp_g) : 16'h0;
      wl  = rnd ? 16'($urandom()) : 16'h0;
      br  = rnd ? 16'($urandom()) : 16'hffff;
      aw_v[w] = !aw_ok && (cyc >= aw_start);
      w_v[w]  = !w_ok;
      wl[w]   = !w_ok && (beats == len - 1);
      awr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bv  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); @(negedge clk);
      if (resp && bv && br[w]) begin
        done = 1;
      end else begin
        if (aw_v[w] && awr) aw_ok = 1;
        if (w_v[w] && wr) begin
          beats++;
          if (wl[w]) w_ok = 1;
        end
        if (aw_ok && w_ok) resp = 1;
      end
      if (done) mptr = (w + 1) % nm;
      checks++;
      if (g_grnt !== exp_g || g_busy !== (done ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL hold: cyc %0d got wgrnt=%h busy=%b, want wgrnt=%h busy=%b",
                 cyc, g_grnt, g_busy, exp_g, !done);
      end
      if (stop_in_resp && resp) break;
      cyc++;
    end
  endtask

  task automatic test_reset();
    nm = 4; park = 1; mptr = 0;
    rst_n = 1'b0;
    zero_inputs();
    @(negedge clk); @(negedge clk);
    checks++;
    if (ifc4.wgrnt !== 4'b0001 || ifc4.wgrnt_id !== 2'd0 || ifc4.wbusy !== 1'b0) begin
      errors++;
      $display("FAIL reset4: got wgrnt=%b id=%0d busy=%b, want 0001 0 0",
               ifc4.wgrnt, ifc4.wgrnt_id, ifc4.wbusy);
    end
    checks++;
    if (ifc3.wgrnt !== 3'b000 || ifc3.wbusy !== 1'b0) begin
      errors++;
      $display("FAIL reset3: got wgrnt=%b busy=%b, want 000 0", ifc3.wgrnt, ifc3.wbusy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (g_grnt !== 16'h0001 || g_id !== 2'd0 || g_busy !== 1'b0) begin
        errors++;
        $display("FAIL park_idle: cyc %0d got wgrnt=%h id=%0d busy=%b, want 0001 0 0",
                 i, g_grnt, g_id, g_busy);
      end
    end
  endtask

  task automatic test_pair();
    int w;
    run_txn(16'h0005, 0, 0, 2, 1, 0, w);
    run_txn(16'h0004, 0, 0, 3, 1, 0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    for (int i = 0; i < 5; i++) run_txn(16'h000f, 0, 0, 4, 1, 0, w);
    for (int i = 0; i < 3; i++) run_txn(16'h000f, 0, 0, 1, 0, 0, w);
  endtask

  task automatic test_w_first();
    int w;
    run_txn(16'h0002, 1, 3, 1, 0, 0, w);
  endtask

  task automatic test_random4();
    int w;
    for (int i = 0; i < 25; i++) begin
      run_txn(16'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(1, 4), 1, 0, w);
    end
  endtask

  task automatic test_reset_in_resp();
    int w;
    run_txn(16'h0008, 0, 0, 1, 0, 1, w);
    rst_n = 1'b0;
    zero_inputs();
    #1;
    checks++;
    if (g_grnt !== 16'h0001 || g_id !== 2'd0 || g_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got wgrnt=%h id=%0d busy=%b, want 0001 0 0", g_grnt, g_id, g_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    run_txn(16'h000a, 0, 0, 2, 1, 0, w);
    run_txn(16'h0008, 0, 0, 2, 1, 0, w);
  endtask

  task automatic test_n3_nopark();
    int w;
    nm = 3; park = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (g_grnt !== 16'h0 || g_busy !== 1'b0) begin
        errors++;
        $display("FAIL n3_idle: got wgrnt=%h busy=%b, want 0 0", g_grnt, g_busy);
      end
    end
    for (int i = 0; i < 4; i++) run_txn(16'h0007, 0, 0, 2, 1, 0, w);
    for (int i = 0; i < 12; i++) begin
      run_txn(16'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              $urandom_range(1, 3), 1'($urandom_range(0, 1)), 0, w);
      if ($urandom_range(0, 1) == 1) begin
        zero_inputs();
        @(posedge clk); @(negedge clk);
        checks++;
        if (g_grnt !== 16'h0 || g_busy !== 1'b0) begin
          errors++;
          $display("FAIL n3_drop: got wgrnt=%h busy=%b, want 0 0", g_grnt, g_busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_back_to_back();
    test_w_first();
    test_random4();
    test_reset_in_resp();
    test_n3_nopark();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
